// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add (LSB first) and divides by radix-2
// restoring shift-subtract (MSB first), one bit per clock. Sign handling
// works on operand magnitudes with a final two's-complement correction.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   execute-stage instruction valid this cycle
//   ALUOp   decoded ALU class; only 3'b011 (M-extension) is acted on
//   funct3  M-op select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   SrcA    rs1 operand
//   SrcB    rs2 operand
//   flush   execute-stage flush; abandons an operation that has not reached FIX
//   busy    operation in progress (PREP, CALC, FIX)
//   stall   combinational hold request for IF/ID/EX
//   done    one-cycle pulse, Result valid
//   Result  registered result, held until the next done
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam logic [2:0]      ALUOP_MULDIV = 3'b011;
    localparam logic [XLEN-1:0] INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_STEP    = 6'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

    state_t            state, state_n;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;        // raw rs2, then multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;        // {high/remainder, low/quotient}
    logic [5:0]        cnt;
    logic              neg_q;      // negate product or quotient
    logic              neg_rem_q;  // negate remainder (dividend sign)
    logic              special_q;  // acc[XLEN-1:0] already holds the final result

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                  input logic is_signed);
        return (is_signed && v < 0) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v,
                                                        input logic neg);
        return neg ? -v : v;
    endfunction

    // Operand decode, evaluated in PREP from the latched operands.
    logic            is_div, a_signed, b_signed, a_neg, b_neg;
    logic            div_by_zero, div_ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, preset;

    assign is_div      = f3_q[2];
    assign a_signed    = (f3_q == 3'b001) || (f3_q == 3'b010) ||
                         (f3_q == 3'b100) || (f3_q == 3'b110);
    assign b_signed    = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
    assign a_neg       = a_signed & a_q[XLEN-1];
    assign b_neg       = b_signed & b_q[XLEN-1];
    assign mag_a       = magnitude(a_q, a_signed);
    assign mag_b       = magnitude(b_q, b_signed);
    assign div_by_zero = is_div && (b_q == '0);
    assign div_ovf     = is_div && !f3_q[0] && (a_q == INT_MIN) && (b_q == '1);
    assign special     = div_by_zero | div_ovf;
    // f3_q[1] distinguishes REM/REMU from DIV/DIVU.
    assign preset      = div_by_zero ? (f3_q[1] ? a_q : '1)
                                     : (f3_q[1] ? '0  : INT_MIN);

    // Multiply step: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Divide step: shift the next dividend bit into the partial remainder and
    // subtract the divisor if it fits. rem_sh needs one extra bit because the
    // shifted remainder can reach 2*divisor-1.
    logic [XLEN:0]     rem_sh;
    logic              fits;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;

    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign fits     = rem_sh >= {1'b0, b_q};
    assign rem_sub  = rem_sh[XLEN-1:0] - b_q;
    assign div_next = fits ? {rem_sub,           acc[XLEN-2:0], 1'b1}
                           : {rem_sh[XLEN-1:0],  acc[XLEN-2:0], 1'b0};

    // Output selection with sign correction, used in FIX.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, result_sel;

    assign prod = cond_neg_wide(acc, neg_q);
    assign quot = cond_neg(acc[XLEN-1:0], neg_q);
    assign rem  = cond_neg(acc[2*XLEN-1:XLEN], neg_rem_q);

    always_comb begin
        result_sel = '0;
        case (f3_q)
            3'b000:                 result_sel = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_sel = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_sel = quot;
            default:                result_sel = rem;
        endcase
    end

    logic accept;
    assign accept = start && (ALUOp == ALUOP_MULDIV) && (state == IDLE) && !flush;

    assign busy  = (state != IDLE);
    assign stall = ~rst & ((start & (ALUOp == ALUOP_MULDIV) & (state == IDLE)) |
                           (busy & ~done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // FIX always completes: the instruction is already committed, so flush
    // cannot cancel it there.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = PREP;
            PREP: begin
                if (flush)        state_n = IDLE;
                else if (special) state_n = FIX;
                else              state_n = CALC;
            end
            CALC: begin
                if (flush)                  state_n = IDLE;
                else if (cnt == LAST_STEP)  state_n = FIX;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q <= funct3;
                        a_q  <= SrcA;
                        b_q  <= SrcB;
                    end
                end
                PREP: begin
                    neg_q     <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    special_q <= special;
                    cnt       <= '0;
                    if (special) begin
                        acc <= {{XLEN{1'b0}}, preset};
                    end else if (is_div) begin
                        // dividend shifts out of the low half MSB first
                        acc <= {{XLEN{1'b0}}, mag_a};
                        b_q <= mag_b;
                    end else begin
                        // multiplier sits in the low half and is consumed LSB first
                        acc <= {{XLEN{1'b0}}, mag_b};
                        b_q <= mag_a;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    acc <= is_div ? div_next : mul_next;
                end
                default: begin
                    Result <= special_q ? acc[XLEN-1:0] : result_sel;
                end
            endcase
        end
    end

endmodule
